mem_access: RTL
===============

// Module: mem_access
// PURPOSE
//   MEM-stage data-memory access unit. It sits between the ex_mem register and mem_wb.
//   Converts the load/store request from EX/MEM into an SRAM-like data-bus transaction.
//   Produces data_stall (stall[0]) for the pipeline and returns the raw load word to mem_wb/WB.
//   Load-data extension and alignment are done in WB using mem_addr and aluop.
// PARAMETERS
//   ADDR_W       32    data address width
//   DATA_W       32    data bus width; fixed 32, strobes are 4 bits
// PORTS
//   clk            in   1       pipeline clock, rising edge
//   rst            in   1       asynchronous reset, active-low
//   exception      in   1       pipeline flush from CP0
//   pipe_stall_i   in   1       OR of inst/id/ex stalls: MEM inputs are held this cycle
//   mem_re_i       in   1       load in MEM this cycle
//   mem_we_i       in   1       store in MEM this cycle (never together with mem_re_i)
//   mem_size_i     in   2       0=byte, 1=half, 2=word
//   mem_addr_i     in   32      effective address
//   rt_data_i      in   32      store source data
//   data_req       out  1       bus request
//   data_wr        out  1       1=write
//   data_size      out  2       copy of mem_size_i
//   data_addr      out  32      bus address
//   data_wdata     out  32      lane-replicated store data
//   data_wstrb     out  4       byte-lane enables (write only, 0 on reads)
//   data_addr_ok   in   1       request accepted
//   data_rdata     in   32      read data, valid while data_data_ok=1
//   data_data_ok   in   1       response (read data or write ack)
//   data_stall_o   out  1       stall[0] to all pipeline registers
//   load_data_o    out  32      raw load word to mem_wb
//   addr_exc_o     out  1       misaligned access flag (see CONFIGURATION)
// BEHAVIOUR
//   op_v = (mem_re_i|mem_we_i) & ~exception.
//   States: IDLE, REQ, WAIT, DONE, DRAIN. Reset: state=IDLE, load_data reg=0.
//     All outputs are 0 during reset.
//   IDLE : data_req=op_v combinationally.
//          Next state: op_v&addr_ok -> WAIT; op_v&~addr_ok -> REQ.
//   REQ  : data_req=1 with the same addr/wdata/wstrb.
//          addr_ok -> WAIT. Exception -> IDLE with req dropped; allowed because it was not accepted.
//   WAIT : data_req=0 until data_ok.
//          data_ok&~exception: load_data_o=data_rdata combinationally, and the register captures it.
//            Then: pipe_stall_i -> DONE, else -> IDLE.
//          exception&~data_ok -> DRAIN.
//          exception&data_ok -> IDLE, response discarded.
//   DONE : no request. load_data_o=captured reg. Exits to IDLE when ~pipe_stall_i.
//          The held op is never reissued.
//   DRAIN: no request, data_stall_o=1. data_ok -> IDLE, data discarded.
//   data_stall_o is 1 in these cases:
//     - IDLE with op_v.
//     - REQ.
//     - WAIT without data_ok.
//     - DRAIN without data_ok.
//   Otherwise data_stall_o=0. Minimum load/store latency is 1 stall cycle (addr_ok then data_ok next).
//   Address and strobes:
//     - data_addr=mem_addr_i; low bits are per CONFIGURATION.
//     - byte: wstrb=1<<addr[1:0], wdata={4{rt[7:0]}}.
//     - half: wstrb=addr[1]?1100:0011, wdata={2{rt[15:0]}}.
//     - word: wstrb=1111, wdata=rt.
//   A new op in the cycle leaving DONE/WAIT→IDLE is issued the following cycle, never the same one.
//   Reset mid-transaction: returns to IDLE immediately; the outstanding response is ignored.
// CONFIGURATION
//   MEM_ADDR_CHECK_EN defined:
//     - Half with addr[0]=1, or word with addr[1:0]!=0, sets addr_exc_o=1 combinationally.
//     - No request is issued and data_stall_o=0.
//     - CP0 raises AdEL/AdES from it.
//   Undefined: addr_exc_o tied 0. Misaligned addresses are aligned down to access size; bus request issued normally.
// TESTING
//   1 Word load 0x1000, addr_ok same cycle, data_ok next cycle rdata=0xDEADBEEF.
//     -> stall exactly 1 cycle; load_data_o=0xDEADBEEF.
//   2 Byte store rt=0x12345678 to 0x2003.
//     -> data_wr=1, wstrb=1000, wdata=0x78787878, addr=0x2003.
//   3 Load with addr_ok held low 3 cycles, then data_ok while pipe_stall_i=1 for 2 cycles.
//     -> req held 3 cycles, state DONE, no reissue, load_data stable.
//   4 exception asserted in WAIT; data_ok arrives 2 cycles later.
//     -> DRAIN, stall=1 until data_ok, data discarded, next op issued afterwards.
//   5 Half load at 0x3001 with MEM_ADDR_CHECK_EN -> addr_exc_o=1, data_req=0, stall=0.
//     Without the macro -> req with addr 0x3000.
//   6 rst low while in REQ -> all outputs 0, state IDLE.

Source files
------------

// File: rtl/mem_access.sv
// mem_access: MEM-stage data-memory access unit.
// Turns the EX/MEM load/store request into an SRAM-like bus transaction,
// raises data_stall_o while the access is in flight and returns the raw load word.
// Optional feature macro: MEM_ADDR_CHECK_EN (misaligned accesses flagged, not issued).
module mem_access #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              exception,
  input  logic              pipe_stall_i,
  input  logic              mem_re_i,
  input  logic              mem_we_i,
  input  logic [1:0]        mem_size_i,
  input  logic [ADDR_W-1:0] mem_addr_i,
  input  logic [DATA_W-1:0] rt_data_i,
  output logic              data_req,
  output logic              data_wr,
  output logic [1:0]        data_size,
  output logic [ADDR_W-1:0] data_addr,
  output logic [DATA_W-1:0] data_wdata,
  output logic [3:0]        data_wstrb,
  input  logic              data_addr_ok,
  input  logic [DATA_W-1:0] data_rdata,
  input  logic              data_data_ok,
  output logic              data_stall_o,
  output logic [DATA_W-1:0] load_data_o,
  output logic              addr_exc_o
);

  typedef enum logic [2:0] {IDLE, REQ, WAIT, DONE, DRAIN} state_t;

  state_t            state;
  state_t            state_next;
  logic [DATA_W-1:0] load_q;
  logic              op_v;
  logic              op_go;
  logic              exc_c;
  logic              capture;
  logic [ADDR_W-1:0] addr_al;
  logic [3:0]        strb;
  logic [DATA_W-1:0] wdata;

  assign op_v    = (mem_re_i | mem_we_i) & ~exception;
  assign capture = (state == WAIT) & data_data_ok & ~exception;

`ifdef MEM_ADDR_CHECK_EN
  logic misaligned;

  // Misaligned half/word accesses are reported instead of issued
  always_comb begin
    misaligned = 1'b0;
    case (mem_size_i)
      2'd0:    misaligned = 1'b0;
      2'd1:    misaligned = mem_addr_i[0];
      default: misaligned = (mem_addr_i[1:0] != 2'b00);
    endcase
  end

  assign op_go   = op_v & ~misaligned;
  assign exc_c   = (mem_re_i | mem_we_i) & misaligned;
  assign addr_al = mem_addr_i;
`else
  assign op_go = op_v;
  assign exc_c = 1'b0;

  // Without checking, low address bits are forced to the access-size alignment
  always_comb begin
    addr_al = mem_addr_i;
    case (mem_size_i)
      2'd0:    addr_al = mem_addr_i;
      2'd1:    addr_al = {mem_addr_i[ADDR_W-1:1], 1'b0};
      default: addr_al = {mem_addr_i[ADDR_W-1:2], 2'b00};
    endcase
  end
`endif

  // Byte-lane enables and lane-replicated store data
  always_comb begin
    strb  = 4'b1111;
    wdata = rt_data_i;
    case (mem_size_i)
      2'd0: begin
        strb  = 4'b0001 << addr_al[1:0];
        wdata = {4{rt_data_i[7:0]}};
      end
      2'd1: begin
        strb  = addr_al[1] ? 4'b1100 : 4'b0011;
        wdata = {2{rt_data_i[15:0]}};
      end
      default: begin
        strb  = 4'b1111;
        wdata = rt_data_i;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  // Load-word capture register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)         load_q <= '0;
    else if (capture) load_q <= data_rdata;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:  if (op_go) state_next = data_addr_ok ? WAIT : REQ;
      REQ: begin
        if (exception)         state_next = IDLE;
        else if (data_addr_ok) state_next = WAIT;
      end
      WAIT: begin
        if (data_data_ok)   state_next = (~exception & pipe_stall_i) ? DONE : IDLE;
        else if (exception) state_next = DRAIN;
      end
      DONE:  if (!pipe_stall_i) state_next = IDLE;
      DRAIN: if (data_data_ok)  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output logic; everything is forced low while reset is asserted
  always_comb begin
    data_req     = 1'b0;
    data_stall_o = 1'b0;
    load_data_o  = load_q;
    data_wr      = mem_we_i;
    data_size    = mem_size_i;
    data_addr    = addr_al;
    data_wdata   = wdata;
    data_wstrb   = mem_we_i ? strb : 4'b0000;
    addr_exc_o   = exc_c;
    case (state)
      IDLE: begin
        data_req     = op_go;
        data_stall_o = op_go;
      end
      REQ: begin
        data_req     = ~exception;
        data_stall_o = 1'b1;
      end
      WAIT: begin
        data_stall_o = ~data_data_ok;
        if (data_data_ok & ~exception) load_data_o = data_rdata;
      end
      DRAIN: data_stall_o = ~data_data_ok;
      default: ;
    endcase
    if (!rst) begin
      data_req     = 1'b0;
      data_stall_o = 1'b0;
      load_data_o  = '0;
      data_wr      = 1'b0;
      data_size    = 2'd0;
      data_addr    = '0;
      data_wdata   = '0;
      data_wstrb   = 4'b0000;
      addr_exc_o   = 1'b0;
    end
  end

endmodule
